// File: rtl/mesh_nic.sv
// Network interface between one processing element and the PE port of a
// mesh router. One single-entry buffer per direction; PE side is a
// four-register memory map, router side a send/ready handshake that only
// injects when the packet's VC bit matches the router's current polarity.
//
// Buffer FSM (one instance per direction)
//   state     | meaning
//   BUF_EMPTY | slot free, may capture a new packet
//   BUF_FULL  | slot holds a packet waiting to be consumed
module mesh_nic #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            addr,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   input  logic                  nicEn,
   input  logic                  nicEnWr,
   input  logic                  net_si,
   output logic                  net_ri,
   input  logic [DATA_WIDTH-1:0] net_di,
   output logic                  net_so,
   input  logic                  net_ro,
   output logic [DATA_WIDTH-1:0] net_do,
   input  logic                  net_polarity
);

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
   localparam logic [1:0] ADDR_IN_STAT = 2'b01;
   localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
   localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

   buf_state_e            in_st_q, in_st_d;
   buf_state_e            out_st_q, out_st_d;
   logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
   logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
   logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
   logic [DATA_WIDTH-1:0] net_do_q, net_do_d;
   logic                  net_so_q, net_so_d;

   logic in_full, out_full;
   logic pe_rd, pe_wr, inject;

   assign in_full  = (in_st_q == BUF_FULL);
   assign out_full = (out_st_q == BUF_FULL);
   assign pe_rd    = nicEn & ~nicEnWr;
   assign pe_wr    = nicEn & nicEnWr;
   // Only inject on the router cycle whose polarity matches the packet VC.
   assign inject   = out_full & net_ro & (out_buf_q[DATA_WIDTH-1] == net_polarity);

   assign net_ri = ~in_full;
   assign net_so = net_so_q;
   assign net_do = net_do_q;
   assign d_out  = d_out_q;

   // State register; reset discards any packet or access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_st_q   <= BUF_EMPTY;
         out_st_q  <= BUF_EMPTY;
         in_buf_q  <= '0;
         out_buf_q <= '0;
         d_out_q   <= '0;
         net_do_q  <= '0;
         net_so_q  <= 1'b0;
      end else begin
         in_st_q   <= in_st_d;
         out_st_q  <= out_st_d;
         in_buf_q  <= in_buf_d;
         out_buf_q <= out_buf_d;
         d_out_q   <= d_out_d;
         net_do_q  <= net_do_d;
         net_so_q  <= net_so_d;
      end
   end

   // Input buffer: router fills it when empty, PE read of the data register drains it.
   always_comb begin
      in_st_d  = in_st_q;
      in_buf_d = in_buf_q;
      unique case (in_st_q)
         BUF_EMPTY: begin
            // A send while full is a router violation and is simply ignored.
            if (net_si) begin
               in_buf_d = net_di;
               in_st_d  = BUF_FULL;
            end
         end
         BUF_FULL: begin
            if (pe_rd && (addr == ADDR_IN_BUF)) in_st_d = BUF_EMPTY;
         end
         default: in_st_d = BUF_EMPTY;
      endcase
   end

   // Output buffer: PE write fills it when empty, injection drains it.
   always_comb begin
      out_st_d  = out_st_q;
      out_buf_d = out_buf_q;
      net_so_d  = 1'b0;
      net_do_d  = net_do_q;
      unique case (out_st_q)
         BUF_EMPTY: begin
            if (pe_wr && (addr == ADDR_OUT_BUF)) begin
               out_buf_d = d_in;
               out_st_d  = BUF_FULL;
            end
         end
         BUF_FULL: begin
            // A write landing on a full slot is dropped, even in the drain cycle.
            if (inject) begin
               net_so_d = 1'b1;
               net_do_d = out_buf_q;
               out_st_d = BUF_EMPTY;
            end
         end
         default: out_st_d = BUF_EMPTY;
      endcase
   end

   // PE read data path; status reads see the pre-edge flag values.
   always_comb begin
      d_out_d = d_out_q;
      if (pe_rd) begin
         unique case (addr)
            ADDR_IN_BUF:   d_out_d = in_buf_q;
            ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
            ADDR_OUT_BUF:  d_out_d = '0;
            ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
            default:       d_out_d = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mesh_nic.sv
module tb_mesh_nic;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    addr;
   logic [DW-1:0] d_in;
   logic [DW-1:0] d_out;
   logic          nicEn, nicEnWr;
   logic          net_si, net_ri;
   logic [DW-1:0] net_di;
   logic          net_so, net_ro;
   logic [DW-1:0] net_do;
   logic          net_polarity;

   int errors = 0;
   int checks = 0;

   // Reference model: the two single-slot mailboxes and the registered outputs.
   logic          m_in_full, m_out_full, m_so;
   logic [DW-1:0] m_in_buf, m_out_buf, m_d_out, m_do;
   logic          pol_pre;

   mesh_nic #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
      .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
      .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
      .net_polarity(net_polarity)
   );

   always #5 clk = ~clk;

   // Advance one clock: update the model from the inputs seen at the edge,
   // then toggle the router polarity and leave outputs settled for sampling.
   task automatic cycle();
      logic rd, wr, inj, nxt_in_full, nxt_out_full;
      logic [DW-1:0] nxt_in_buf, nxt_out_buf, nxt_d_out;
      pol_pre = net_polarity;
      @(posedge clk);
      if (!rst) begin
         m_in_full = 0; m_out_full = 0; m_in_buf = '0; m_out_buf = '0;
         m_d_out = '0; m_so = 0; m_do = '0;
      end else begin
         rd = nicEn && !nicEnWr;
         wr = nicEn && nicEnWr;
         inj = m_out_full && net_ro && (m_out_buf[DW-1] == net_polarity);
         nxt_in_full = m_in_full; nxt_in_buf = m_in_buf;
         nxt_out_full = m_out_full; nxt_out_buf = m_out_buf;
         nxt_d_out = m_d_out;
         if (net_si && !m_in_full) begin nxt_in_buf = net_di; nxt_in_full = 1; end
         if (rd && addr == 2'd0 && m_in_full) nxt_in_full = 0;
         if (rd) begin
            if (addr == 2'd0) nxt_d_out = m_in_buf;
            else if (addr == 2'd1) nxt_d_out = DW'(m_in_full);
            else if (addr == 2'd3) nxt_d_out = DW'(m_out_full);
            else nxt_d_out = '0;
         end
         if (wr && addr == 2'd2 && !m_out_full) begin nxt_out_buf = d_in; nxt_out_full = 1; end
         if (inj) begin nxt_out_full = 0; m_do = m_out_buf; end
         m_so = inj;
         m_in_full = nxt_in_full; m_in_buf = nxt_in_buf;
         m_out_full = nxt_out_full; m_out_buf = nxt_out_buf;
         m_d_out = nxt_d_out;
      end
      #1;
      net_polarity = ~net_polarity;
   endtask

   task automatic pe_access(input logic w, input logic [1:0] a, input logic [DW-1:0] d);
      nicEn = 1; nicEnWr = w; addr = a; d_in = d;
      cycle();
      nicEn = 0; nicEnWr = 0;
   endtask

   task automatic test_reset();
      rst = 0; net_si = 1; net_di = 64'hDEAD;
      cycle(); cycle();
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_net_ri got=%b exp=1", net_ri); end
      checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
      checks++; if (net_do !== '0) begin errors++; $display("FAIL reset_net_do got=%h exp=0", net_do); end
      net_si = 0; rst = 1;
      pe_access(0, 2'd1, '0);
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_status01 got=%h exp=0", d_out); end
   endtask

   task automatic test_inject_even();
      int pulses = 0;
      logic fire_pol = 1'bx;
      net_ro = 1;
      pe_access(1, 2'd2, 64'h00A5);
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (net_so !== m_so) begin errors++; $display("FAIL even_so_model cyc=%0d got=%b exp=%b", i, net_so, m_so); end
         if (net_so === 1'b1) begin
            pulses++; fire_pol = pol_pre;
            checks++; if (net_do !== 64'h00A5) begin errors++; $display("FAIL even_net_do got=%h exp=a5", net_do); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL even_pulses got=%0d exp=1", pulses); end
      checks++; if (fire_pol !== 1'b0) begin errors++; $display("FAIL even_polarity got=%b exp=0", fire_pol); end
      pe_access(0, 2'd3, '0);
      checks++; if (d_out !== '0) begin errors++; $display("FAIL even_status11 got=%h exp=0", d_out); end
   endtask

   task automatic test_inject_blocked();
      int pulses = 0;
      logic fire_pol = 1'bx;
      net_ro = 0;
      pe_access(1, 2'd2, 64'h8000_0000_0000_0001);
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL blocked_no_so cyc=%0d got=%b exp=0", i, net_so); end
      end
      pe_access(1, 2'd2, 64'h2);
      pe_access(0, 2'd3, '0);
      checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL blocked_status11 got=%h exp=1", d_out); end
      net_ro = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (net_so === 1'b1) begin
            pulses++; fire_pol = pol_pre;
            checks++; if (net_do !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL blocked_net_do got=%h exp=8000000000000001", net_do); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL blocked_pulses got=%0d exp=1", pulses); end
      checks++; if (fire_pol !== 1'b1) begin errors++; $display("FAIL blocked_polarity got=%b exp=1", fire_pol); end
      checks++; if (net_do !== 64'h8000_0000_0000_0001) begin errors++; $display("FAIL blocked_do_hold got=%h exp=8000000000000001", net_do); end
   endtask

   task automatic test_receive();
      net_si = 1; net_di = 64'h1234;
      cycle();
      net_si = 0;
      checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL recv_net_ri_busy got=%b exp=0", net_ri); end
      pe_access(0, 2'd1, '0);
      checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL recv_status01 got=%h exp=1", d_out); end
      pe_access(0, 2'd0, '0);
      checks++; if (d_out !== 64'h1234) begin errors++; $display("FAIL recv_data got=%h exp=1234", d_out); end
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL recv_net_ri_free got=%b exp=1", net_ri); end
      cycle();
      checks++; if (d_out !== 64'h1234) begin errors++; $display("FAIL recv_d_out_hold got=%h exp=1234", d_out); end
   endtask

   task automatic test_backpressure();
      net_si = 1; net_di = 64'hBEEF;
      cycle();
      net_di = 64'h1;
      cycle(); cycle();
      net_si = 0;
      checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL bp_net_ri got=%b exp=0", net_ri); end
      pe_access(0, 2'd0, '0);
      checks++; if (d_out !== 64'hBEEF) begin errors++; $display("FAIL bp_data got=%h exp=beef", d_out); end
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL bp_drained got=%b exp=1", net_ri); end
   endtask

   task automatic test_reset_mid();
      net_ro = 0;
      net_si = 1; net_di = 64'h55;
      cycle();
      net_si = 0;
      pe_access(1, 2'd2, 64'h77);
      checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL mid_pre_full got=%b exp=0", net_ri); end
      rst = 0; net_ro = 1;
      cycle();
      rst = 1;
      checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL mid_in_full_clr got=%b exp=1", net_ri); end
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL mid_no_so cyc=%0d got=%b exp=0", i, net_so); end
      end
      pe_access(0, 2'd3, '0);
      checks++; if (d_out !== '0) begin errors++; $display("FAIL mid_status11 got=%h exp=0", d_out); end
      pe_access(0, 2'd1, '0);
      checks++; if (d_out !== '0) begin errors++; $display("FAIL mid_status01 got=%h exp=0", d_out); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 49) != 0);
         nicEn   = $urandom_range(0, 1);
         nicEnWr = $urandom_range(0, 1);
         addr    = 2'($urandom_range(0, 3));
         d_in    = {$urandom, $urandom};
         net_si  = ($urandom_range(0, 2) == 0);
         net_di  = {$urandom, $urandom};
         net_ro  = ($urandom_range(0, 3) != 0);
         cycle();
         checks++;
         if (net_so !== m_so || net_do !== m_do || d_out !== m_d_out || net_ri !== !m_in_full) begin
            errors++;
            $display("FAIL rand cyc=%0d so=%b/%b do=%h/%h d_out=%h/%h ri=%b/%b (got/exp)",
                     i, net_so, m_so, net_do, m_do, d_out, m_d_out, net_ri, !m_in_full);
         end
      end
      rst = 1; nicEn = 0; net_si = 0;
   endtask

   initial begin
      rst = 0; addr = 0; d_in = '0; nicEn = 0; nicEnWr = 0;
      net_si = 0; net_di = '0; net_ro = 0; net_polarity = 0;
      m_in_full = 0; m_out_full = 0; m_so = 0;
      m_in_buf = '0; m_out_buf = '0; m_d_out = '0; m_do = '0;
      test_reset();
      test_inject_even();
      test_inject_blocked();
      test_receive();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
